// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// requesters. The accepted op is registered, driven to the ALU for one
// cycle, and the captured result is held until the granted port takes it.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   reqN_valid/ready/a/b/ctrl   request handshake and operands, N = 0, 1
//   respN_valid/ready           response handshake, N = 0, 1
//   resp_out/zero/err           shared captured result, qualified by respN_valid
//   alu_a/b/ctrl                registered drive to the shared ALU
//   alu_out/alu_zero            combinational ALU return
module alu_arbiter #(
   parameter int width = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [width-1:0] req0_a,
   input  logic [width-1:0] req0_b,
   input  logic [3:0]       req0_ctrl,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [width-1:0] req1_a,
   input  logic [width-1:0] req1_b,
   input  logic [3:0]       req1_ctrl,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [width-1:0] resp_out,
   output logic             resp_zero,
   output logic             resp_err,
   output logic [width-1:0] alu_a,
   output logic [width-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [width-1:0] alu_out,
   input  logic             alu_zero
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             gnt_q, gnt_d;
   logic [width-1:0] alu_a_q, alu_a_d;
   logic [width-1:0] alu_b_q, alu_b_d;
   logic [3:0]       alu_ctrl_q, alu_ctrl_d;
   logic [width-1:0] resp_out_q, resp_out_d;
   logic             resp_zero_q, resp_zero_d;
   logic             resp_err_q, resp_err_d;

   logic             win0, win1;
   logic             idle;
   logic             ctrl_bad;
   logic             resp_take;

   // ptr_q names the port that wins a tie; a lone valid always wins.
   always_comb begin
      win0 = req0_valid & (~req1_valid | ~ptr_q);
      win1 = req1_valid & (~req0_valid | ptr_q);
   end

   // rst_n gates ready so no handshake is offered while reset is held.
   assign idle       = rst_n & (state_q == IDLE);
   assign req0_ready = idle & win0;
   assign req1_ready = idle & win1;

   assign resp0_valid = (state_q == RESP) & ~gnt_q;
   assign resp1_valid = (state_q == RESP) & gnt_q;
   assign resp_take   = gnt_q ? resp1_ready : resp0_ready;

   assign resp_out  = resp_out_q;
   assign resp_zero = resp_zero_q;
   assign resp_err  = resp_err_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_ctrl  = alu_ctrl_q;

   // Codes with no ALU operation behind them.
   always_comb begin
      ctrl_bad = 1'b0;
      case (alu_ctrl_q)
         4'b0110,
         4'b0111,
         4'b1101,
         4'b1111: ctrl_bad = 1'b1;
         default: ctrl_bad = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_ctrl_d  = alu_ctrl_q;
      resp_out_d  = resp_out_q;
      resp_zero_d = resp_zero_q;
      resp_err_d  = resp_err_q;
      unique case (state_q)
         IDLE: begin
            unique case (1'b1)
               win0: begin
                  alu_a_d    = req0_a;
                  alu_b_d    = req0_b;
                  alu_ctrl_d = req0_ctrl;
                  gnt_d      = 1'b0;
                  ptr_d      = 1'b1;
                  state_d    = EXEC;
               end
               win1: begin
                  alu_a_d    = req1_a;
                  alu_b_d    = req1_b;
                  alu_ctrl_d = req1_ctrl;
                  gnt_d      = 1'b1;
                  ptr_d      = 1'b0;
                  state_d    = EXEC;
               end
               default: state_d = IDLE;
            endcase
         end
         EXEC: begin
            resp_out_d  = alu_out;
            resp_zero_d = alu_zero;
            resp_err_d  = ctrl_bad;
            state_d     = RESP;
         end
         RESP: begin
            if (resp_take) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         gnt_q       <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_ctrl_q  <= '0;
         resp_out_q  <= '0;
         resp_zero_q <= 1'b0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_ctrl_q  <= alu_ctrl_d;
         resp_out_q  <= resp_out_d;
         resp_zero_q <= resp_zero_d;
         resp_err_q  <= resp_err_d;
      end
   end

endmodule
